// File: rtl/audio_cfg_sequencer_pkg.sv
// Shared definitions for the audio configuration sequencer: register map,
// sequencer states, configuration bank layout and the level/attenuation helpers.
package audio_cfg_sequencer_pkg;

  localparam logic [3:0] ADDR_RATE_LO = 4'h0;
  localparam logic [3:0] ADDR_RATE_HI = 4'h1;
  localparam logic [3:0] ADDR_CX_0    = 4'h2;
  localparam logic [3:0] ADDR_CX_1    = 4'h3;
  localparam logic [3:0] ADDR_CX_2    = 4'h4;
  localparam logic [3:0] ADDR_CX0     = 4'h5;
  localparam logic [3:0] ADDR_CX1     = 4'h6;
  localparam logic [3:0] ADDR_CX2     = 4'h7;
  localparam logic [3:0] ADDR_CY0_LO  = 4'h8;
  localparam logic [3:0] ADDR_CY0_HI  = 4'h9;
  localparam logic [3:0] ADDR_CY1_LO  = 4'hA;
  localparam logic [3:0] ADDR_CY1_HI  = 4'hB;
  localparam logic [3:0] ADDR_CY2_LO  = 4'hC;
  localparam logic [3:0] ADDR_CY2_HI  = 4'hD;
  localparam logic [3:0] ADDR_ATT     = 4'hE;

  localparam logic [4:0] LEVEL_MUTE = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FADE_OUT,
    ST_SWAP,
    ST_SETTLE,
    ST_FADE_IN
  } seq_state_t;

  typedef struct packed {
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;
    logic [1:0]  mix;
  } cfg_bank_t;

  // Attenuation code with bit4 set means full mute regardless of the low bits.
  function automatic logic [4:0] att_to_level(input logic [4:0] att_code);
    return att_code[4] ? LEVEL_MUTE : {1'b0, att_code[3:0]};
  endfunction

  function automatic logic [4:0] level_to_att(input logic [4:0] level);
    return (level == LEVEL_MUTE) ? 5'h10 : {1'b0, level[3:0]};
  endfunction

endpackage

// File: rtl/audio_cfg_sequencer_if.sv
// Register-write / commit port of the audio configuration sequencer.
interface audio_cfg_sequencer_if;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] din;
  logic        commit;
  logic        busy;

  modport master (output wr, addr, din, commit, input busy);
  modport slave  (input wr, addr, din, commit, output busy);
endinterface

// File: rtl/audio_att_ramp.sv
// Attenuation level ramp: moves level one step toward target every RAMP_DIV
// sample strobes while enabled; the step timer reloads on restart.
module audio_att_ramp
  import audio_cfg_sequencer_pkg::*;
#(
  parameter int RAMP_DIV = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_ce,
  input  logic       restart,
  input  logic       enable,
  input  logic [4:0] target,
  output logic [4:0] level,
  output logic       done
);

  localparam logic [CNT_W-1:0] STEP_RELOAD = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] step_tmr;
  logic             step;

  assign step = enable && sample_ce && !restart && (step_tmr == '0);
  assign done = (level == target);

  always_ff @(posedge clk) begin
    if (reset) begin
      step_tmr <= '0;
      level    <= LEVEL_MUTE;
    end else begin
      if (restart)
        step_tmr <= STEP_RELOAD;
      else if (enable && sample_ce)
        step_tmr <= (step_tmr == '0) ? STEP_RELOAD : step_tmr - CNT_W'(1);

      // Target never exceeds LEVEL_MUTE, so level stays clamped to 0..16.
      if (step) begin
        if (level < target)
          level <= level + 5'd1;
        else if (level > target)
          level <= level - 5'd1;
      end
    end
  end

endmodule

// File: rtl/audio_cfg_sequencer.sv
// Click-free audio configuration sequencer: shadow register bank, commit FSM
// (fade out, atomic swap with filter reset, settle, fade in) and commit queueing.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | waiting for commit (or a queued one)
//  FADE_OUT | ramp level toward mute
//  SWAP     | one clk: shadow -> active, flt_reset pulse, clear coef_dirty
//  SETTLE   | hold mute for SETTLE_SAMPLES sample strobes
//  FADE_IN  | ramp level toward the current attenuation target
module audio_cfg_sequencer
  import audio_cfg_sequencer_pkg::*;
#(
  parameter logic [31:0] DEF_FLT_RATE   = 32'd7056000,
  parameter int          RAMP_DIV       = 4,
  parameter int          SETTLE_SAMPLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_ce,
  audio_cfg_sequencer_if.slave   cfg,
  output logic [31:0]            flt_rate,
  output logic [39:0]            cx,
  output logic [7:0]             cx0,
  output logic [7:0]             cx1,
  output logic [7:0]             cx2,
  output logic [23:0]            cy0,
  output logic [23:0]            cy1,
  output logic [23:0]            cy2,
  output logic [4:0]             att,
  output logic [1:0]             mix,
  output logic                   flt_reset
);

  localparam int CNT_W = $clog2((RAMP_DIV > SETTLE_SAMPLES) ? RAMP_DIV : SETTLE_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_SAMPLES - 1);
  localparam cfg_bank_t RESET_BANK = '{flt_rate: DEF_FLT_RATE, cx: '0, cx0: '0, cx1: '0,
                                       cx2: '0, cy0: '0, cy1: '0, cy2: '0, mix: '0};

  seq_state_t       state, state_nxt;
  cfg_bank_t        shadow, active;
  logic [4:0]       tgt_att;
  logic             coef_dirty, commit_pend, busy_q;
  logic [CNT_W-1:0] settle_tmr;
  logic             coef_wr, dirty_now, commit_now, restart;
  logic             ramp_en, ramp_done;
  logic [4:0]       ramp_target, level;

  // A coefficient write in the same clk as a commit counts toward its decision.
  assign coef_wr    = cfg.wr && (cfg.addr <= ADDR_CY2_HI);
  assign dirty_now  = coef_dirty || coef_wr;
  assign commit_now = cfg.commit || commit_pend;
  assign restart    = (state_nxt != state);

  always_comb begin
    state_nxt   = state;
    ramp_en     = 1'b0;
    ramp_target = LEVEL_MUTE;
    unique case (state)
      ST_IDLE:     if (commit_now) state_nxt = dirty_now ? ST_FADE_OUT : ST_FADE_IN;
      ST_FADE_OUT: begin
        ramp_en = 1'b1;
        if (ramp_done) state_nxt = ST_SWAP;
      end
      ST_SWAP:     state_nxt = ST_SETTLE;
      ST_SETTLE:   if (sample_ce && settle_tmr == '0) state_nxt = ST_FADE_IN;
      ST_FADE_IN: begin
        ramp_en     = 1'b1;
        ramp_target = att_to_level(tgt_att);
        if (ramp_done) state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      commit_pend <= 1'b0;
      coef_dirty  <= 1'b1;
      tgt_att     <= 5'h10;
      settle_tmr  <= '0;
      shadow      <= RESET_BANK;
      active      <= RESET_BANK;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);

      if (state == ST_IDLE)
        commit_pend <= 1'b0;
      else if (cfg.commit)
        commit_pend <= 1'b1;

      if (restart)
        settle_tmr <= SETTLE_RELOAD;
      else if (state == ST_SETTLE && sample_ce && settle_tmr != '0)
        settle_tmr <= settle_tmr - CNT_W'(1);

      // Copy uses the pre-write shadow; a write in the SWAP clk leaves the bank dirty.
      if (state == ST_SWAP) begin
        active     <= shadow;
        coef_dirty <= 1'b0;
      end
      if (coef_wr)
        coef_dirty <= 1'b1;

      if (cfg.wr) begin
        case (cfg.addr)
          ADDR_RATE_LO: shadow.flt_rate[15:0]  <= cfg.din;
          ADDR_RATE_HI: shadow.flt_rate[31:16] <= cfg.din;
          ADDR_CX_0:    shadow.cx[15:0]        <= cfg.din;
          ADDR_CX_1:    shadow.cx[31:16]       <= cfg.din;
          ADDR_CX_2:    shadow.cx[39:32]       <= cfg.din[7:0];
          ADDR_CX0:     shadow.cx0             <= cfg.din[7:0];
          ADDR_CX1:     shadow.cx1             <= cfg.din[7:0];
          ADDR_CX2:     shadow.cx2             <= cfg.din[7:0];
          ADDR_CY0_LO:  shadow.cy0[15:0]       <= cfg.din;
          ADDR_CY0_HI:  shadow.cy0[23:16]      <= cfg.din[7:0];
          ADDR_CY1_LO:  shadow.cy1[15:0]       <= cfg.din;
          ADDR_CY1_HI:  shadow.cy1[23:16]      <= cfg.din[7:0];
          ADDR_CY2_LO:  shadow.cy2[15:0]       <= cfg.din;
          ADDR_CY2_HI:  shadow.cy2[23:16]      <= cfg.din[7:0];
          ADDR_ATT: begin
            tgt_att    <= cfg.din[4:0];
            shadow.mix <= cfg.din[9:8];
          end
          default: ;
        endcase
      end
    end
  end

  audio_att_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .CNT_W    (CNT_W)
  ) u_att_ramp (
    .clk       (clk),
    .reset     (reset),
    .sample_ce (sample_ce),
    .restart   (restart),
    .enable    (ramp_en),
    .target    (ramp_target),
    .level     (level),
    .done      (ramp_done)
  );

  assign cfg.busy  = busy_q;
  assign flt_reset = (state == ST_SWAP);
  assign att       = level_to_att(level);
  assign flt_rate  = active.flt_rate;
  assign cx        = active.cx;
  assign cx0       = active.cx0;
  assign cx1       = active.cx1;
  assign cx2       = active.cx2;
  assign cy0       = active.cy0;
  assign cy1       = active.cy1;
  assign cy2       = active.cy2;
  assign mix       = active.mix;

endmodule

// File: tb/tb_audio_cfg_sequencer.sv
// Directed bench for audio_cfg_sequencer: register-map table plus hand-written
// fade/swap/settle, queued-commit, swap-clk write and mid-sequence reset cases.
module tb_audio_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_ce;
  logic [31:0] flt_rate;
  logic [39:0] cx;
  logic [7:0]  cx0, cx1, cx2;
  logic [23:0] cy0, cy1, cy2;
  logic [4:0]  att;
  logic [1:0]  mix;
  logic        flt_reset;

  int checks   = 0;
  int failures = 0;
  int fr_cnt   = 0;
  int busy_rise = 0;
  logic busy_prev = 1'b0;

  audio_cfg_sequencer_if cfg_if ();

  audio_cfg_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .sample_ce (sample_ce),
    .cfg       (cfg_if),
    .flt_rate  (flt_rate),
    .cx        (cx),
    .cx0       (cx0),
    .cx1       (cx1),
    .cx2       (cx2),
    .cy0       (cy0),
    .cy1       (cy1),
    .cy2       (cy2),
    .att       (att),
    .mix       (mix),
    .flt_reset (flt_reset)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (flt_reset) fr_cnt++;
    if (cfg_if.busy && !busy_prev) busy_rise++;
    busy_prev = cfg_if.busy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    bit          chk;
    int          fld;
    logic [39:0] exp;
    string       name;
  } vec_t;

  localparam int F_RATE = 0, F_CX = 1, F_CX0 = 2, F_CX1 = 3, F_CX2 = 4,
                 F_CY0 = 5, F_CY1 = 6, F_CY2 = 7, F_MIX = 8, F_ATT = 9;

  vec_t tbl [16];

  function automatic logic [39:0] get_field(input int f);
    case (f)
      F_RATE:  return {8'h0, flt_rate};
      F_CX:    return cx;
      F_CX0:   return {32'h0, cx0};
      F_CX1:   return {32'h0, cx1};
      F_CX2:   return {32'h0, cx2};
      F_CY0:   return {16'h0, cy0};
      F_CY1:   return {16'h0, cy1};
      F_CY2:   return {16'h0, cy2};
      F_MIX:   return {38'h0, mix};
      default: return {35'h0, att};
    endcase
  endfunction

  task automatic set_vec(input int i, input logic [3:0] a, input logic [15:0] d,
                         input bit c, input int f, input logic [39:0] e, input string n);
    tbl[i].addr = a; tbl[i].data = d; tbl[i].chk = c;
    tbl[i].fld = f;  tbl[i].exp = e;  tbl[i].name = n;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ce(input int n);
    for (int i = 0; i < n; i++) begin
      sample_ce = 1'b1; tick();
      sample_ce = 1'b0; tick();
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    cfg_if.wr = 1'b1; cfg_if.addr = a; cfg_if.din = d;
    tick();
    cfg_if.wr = 1'b0;
  endtask

  task automatic do_commit();
    cfg_if.commit = 1'b1;
    tick();
    cfg_if.commit = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (cfg_if.busy && n < budget) begin
      ce(1);
      n++;
    end
    check(name, {39'h0, cfg_if.busy}, 40'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_att"}, {35'h0, att}, 40'h10);
    check({tag, "_busy"}, {39'h0, cfg_if.busy}, 40'h0);
    check({tag, "_flt_reset"}, {39'h0, flt_reset}, 40'h0);
    check({tag, "_rate"}, get_field(F_RATE), 40'd7056000);
    for (int f = F_CX; f <= F_MIX; f++)
      check($sformatf("%s_fld%0d", tag, f), get_field(f), 40'h0);
  endtask

  initial begin
    int fr_base, rise_base;

    set_vec(0,  4'h0, 16'h1234, 1'b0, F_RATE, 40'h0,          "rate_lo");
    set_vec(1,  4'h1, 16'h0056, 1'b1, F_RATE, 40'h0000561234, "tbl_rate");
    set_vec(2,  4'h2, 16'hBEEF, 1'b0, F_CX,   40'h0,          "cx_lo");
    set_vec(3,  4'h3, 16'hDEAD, 1'b0, F_CX,   40'h0,          "cx_mid");
    set_vec(4,  4'h4, 16'h00A5, 1'b1, F_CX,   40'hA5DEADBEEF, "tbl_cx");
    set_vec(5,  4'h5, 16'h0011, 1'b1, F_CX0,  40'h11,         "tbl_cx0");
    set_vec(6,  4'h6, 16'hFF22, 1'b1, F_CX1,  40'h22,         "tbl_cx1");
    set_vec(7,  4'h7, 16'h0033, 1'b1, F_CX2,  40'h33,         "tbl_cx2");
    set_vec(8,  4'h8, 16'hABCD, 1'b0, F_CY0,  40'h0,          "cy0_lo");
    set_vec(9,  4'h9, 16'h0000, 1'b1, F_CY0,  40'h00ABCD,     "tbl_cy0");
    set_vec(10, 4'hA, 16'h0001, 1'b0, F_CY1,  40'h0,          "cy1_lo");
    set_vec(11, 4'hB, 16'h0002, 1'b1, F_CY1,  40'h020001,     "tbl_cy1");
    set_vec(12, 4'hC, 16'hFFFF, 1'b0, F_CY2,  40'h0,          "cy2_lo");
    set_vec(13, 4'hD, 16'h00FF, 1'b1, F_CY2,  40'hFFFFFF,     "tbl_cy2");
    set_vec(14, 4'hE, 16'h0310, 1'b1, F_MIX,  40'h3,          "tbl_mix");
    set_vec(15, 4'hF, 16'hFFFF, 1'b1, F_ATT,  40'h10,         "tbl_att");

    reset = 1'b1; sample_ce = 1'b0;
    cfg_if.wr = 1'b0; cfg_if.addr = '0; cfg_if.din = '0; cfg_if.commit = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset values
    check_reset_outputs("rst");

    // Register map: write every address, nothing visible until commit
    for (int i = 0; i < 16; i++) wr_reg(tbl[i].addr, tbl[i].data);
    check("pre_commit_rate", get_field(F_RATE), 40'd7056000);
    fr_base = fr_cnt;
    do_commit();
    check("tbl_busy", {39'h0, cfg_if.busy}, 40'h1);
    wait_idle(1000, "tbl_idle");
    check("tbl_fr_pulses", 40'(fr_cnt - fr_base), 40'd1);
    for (int i = 0; i < 16; i++)
      if (tbl[i].chk) check(tbl[i].name, get_field(tbl[i].fld), tbl[i].exp);

    // Attenuation-only commit: 16 -> 3, one step per 4 strobes, no swap
    fr_base = fr_cnt;
    wr_reg(4'hE, 16'h0003);
    do_commit();
    check("t2_busy", {39'h0, cfg_if.busy}, 40'h1);
    for (int s = 1; s <= 13; s++) begin
      ce(3);
      check($sformatf("t2_hold%0d", s), {35'h0, att}, 40'(16 - (s - 1)));
      ce(1);
      check($sformatf("t2_step%0d", s), {35'h0, att}, 40'(16 - s));
    end
    check("t2_busy_fall", {39'h0, cfg_if.busy}, 40'h0);
    check("t2_no_fr", 40'(fr_cnt - fr_base), 40'd0);
    check("t2_mix_kept", {38'h0, mix}, 40'h3);

    // Full commit from L=3: fade out, swap, settle, fade in
    fr_base = fr_cnt;
    wr_reg(4'h8, 16'h3456);
    wr_reg(4'h9, 16'h0012);
    do_commit();
    ce(26);
    check("t3_fade_mid", {35'h0, att}, 40'd9);
    check("t3_cy0_old_mid", {16'h0, cy0}, 40'h00ABCD);
    ce(26);
    check("t3_swap_att", {35'h0, att}, 40'h10);
    check("t3_swap_pulse", {39'h0, flt_reset}, 40'h1);
    check("t3_cy0_pre", {16'h0, cy0}, 40'h00ABCD);
    tick();
    check("t3_cy0_post", {16'h0, cy0}, 40'h123456);
    check("t3_pulse_end", {39'h0, flt_reset}, 40'h0);
    ce(255);
    check("t3_settle_att", {35'h0, att}, 40'h10);
    check("t3_settle_busy", {39'h0, cfg_if.busy}, 40'h1);
    ce(1);
    ce(51);
    check("t3_fadein_att", {35'h0, att}, 40'd4);
    check("t3_fadein_busy", {39'h0, cfg_if.busy}, 40'h1);
    ce(1);
    check("t3_final_att", {35'h0, att}, 40'd3);
    check("t3_busy_fall", {39'h0, cfg_if.busy}, 40'h0);
    check("t3_fr_pulses", 40'(fr_cnt - fr_base), 40'd1);
    check("t3_mix_swapped", {38'h0, mix}, 40'h0);

    // Commit during FADE_OUT is queued and runs as an att-only pass afterwards
    fr_base = fr_cnt; rise_base = busy_rise;
    wr_reg(4'h5, 16'h00AB);
    do_commit();
    ce(8);
    check("t4_fade_att", {35'h0, att}, 40'd5);
    do_commit();
    wait_idle(2000, "t4_idle");
    repeat (6) tick();
    check("t4_busy_end", {39'h0, cfg_if.busy}, 40'h0);
    check("t4_two_seqs", 40'(busy_rise - rise_base), 40'd2);
    check("t4_one_swap", 40'(fr_cnt - fr_base), 40'd1);
    check("t4_cx0", {32'h0, cx0}, 40'hAB);
    check("t4_att", {35'h0, att}, 40'd3);

    // Write in the SWAP clk lands after the copy and leaves the bank dirty
    wr_reg(4'hA, 16'h0009);
    do_commit();
    ce(52);
    check("t5_in_swap", {39'h0, flt_reset}, 40'h1);
    cfg_if.wr = 1'b1; cfg_if.addr = 4'h8; cfg_if.din = 16'h0777;
    tick();
    cfg_if.wr = 1'b0;
    check("t5_cy1_swapped", {16'h0, cy1}, 40'h020009);
    check("t5_cy0_precopy", {16'h0, cy0}, 40'h123456);
    wait_idle(2000, "t5_idle1");
    fr_base = fr_cnt;
    do_commit();
    wait_idle(2000, "t5_idle2");
    check("t5_second_swap", 40'(fr_cnt - fr_base), 40'd1);
    check("t5_cy0_new", {16'h0, cy0}, 40'h120777);

    // Reset during SETTLE aborts with no partial swap
    wr_reg(4'h7, 16'h0055);
    do_commit();
    ce(52);
    tick();
    ce(10);
    fr_base = fr_cnt;
    reset = 1'b1;
    tick();
    check_reset_outputs("t6");
    reset = 1'b0;
    ce(5);
    check("t6_no_pulse", 40'(fr_cnt - fr_base), 40'd0);
    check("t6_att_idle", {35'h0, att}, 40'h10);
    check("t6_cx2_kept", {32'h0, cx2}, 40'h0);
    do_commit();
    tick();
    check("t6_dirty_swap", {39'h0, flt_reset}, 40'h1);
    wait_idle(2000, "t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
